// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the frame arbiter family.
package axis_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    HOLD = 2'd2
  } arb_state_t;

  // Width of a FIFO depth/status field: must hold the value DEPTH itself.
  function automatic int depth_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker: first set req bit searching upward
// from last_grant+1, wrapping modulo NUM_PORTS.
module rr_priority_select #(
  parameter int NUM_PORTS = 4,
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IW-1:0]        last_grant,
  output logic                 found,
  output logic [IW-1:0]        index
);

  // Scan all ports once, starting just after the previous winner.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    index = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_PORTS) idx -= NUM_PORTS;
      if (!found && req[idx]) begin
        found = 1'b1;
        index = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/axis_fifo_frame_arbiter.sv
// Round-robin frame scheduler merging NUM_PORTS frame-mode AXIS FIFOs.
// A grant holds for a full frame; sticky error flags and a frame counter
// are exposed for software.
module axis_fifo_frame_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  localparam int DW = depth_width(DEPTH),
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS*DW-1:0]         fifo_depth_commit,
  input  logic [NUM_PORTS-1:0]            fifo_overflow,
  input  logic [NUM_PORTS-1:0]            fifo_bad_frame,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic                            grant_valid,
  output logic [IW-1:0]                   grant_index,
  output logic [NUM_PORTS-1:0]            overflow_sticky,
  output logic [NUM_PORTS-1:0]            bad_frame_sticky,
  input  logic [NUM_PORTS-1:0]            sticky_clear,
  output logic [31:0]                     frames_forwarded
);

  arb_state_t           state;
  logic [IW-1:0]        last_grant;
  logic                 hold_idle;
  logic                 holdoff_on;
  logic [NUM_PORTS-1:0] eligible;
  logic                 pick_found;
  logic [IW-1:0]        pick_index;

  // The just-served port is masked in HOLD and the IDLE after it, so a
  // depth_commit that has not yet caught up cannot regrant it.
  assign holdoff_on = (state == HOLD) || hold_idle;

  // Eligible ports: committed frame present and not in holdoff.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      eligible[i] = (fifo_depth_commit[i*DW +: DW] != '0) &&
                    !(holdoff_on && (last_grant == IW'(i)));
  end

  rr_priority_select #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req        (eligible),
    .last_grant (last_grant),
    .found      (pick_found),
    .index      (pick_index)
  );

  // Passthrough of the granted port while in XFER; quiet otherwise.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state == XFER) begin
      m_axis_tdata               = s_axis_tdata[int'(grant_index)*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tvalid              = s_axis_tvalid[grant_index];
      m_axis_tlast               = s_axis_tlast[grant_index];
      s_axis_tready[grant_index] = m_axis_tready;
    end
  end

  // Arbitration FSM with registered grant outputs and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      grant_valid      <= 1'b0;
      grant_index      <= '0;
      last_grant       <= IW'(NUM_PORTS - 1);
      hold_idle        <= 1'b0;
      frames_forwarded <= '0;
    end else begin
      hold_idle <= (state == HOLD);
      case (state)
        IDLE: if (pick_found) begin
          grant_index <= pick_index;
          grant_valid <= 1'b1;
          state       <= XFER;
        end
        XFER: if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          last_grant       <= grant_index;
          frames_forwarded <= frames_forwarded + 32'd1;
          grant_valid      <= 1'b0;
          state            <= HOLD;
        end
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky error flags; a set pulse beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_sticky  <= '0;
      bad_frame_sticky <= '0;
    end else begin
      overflow_sticky  <= (overflow_sticky  & ~sticky_clear) | fifo_overflow;
      bad_frame_sticky <= (bad_frame_sticky & ~sticky_clear) | fifo_bad_frame;
    end
  end

endmodule
